// File: rtl/dmux_n_pkg.sv
// Shared types and helpers for the dmux_n registered demultiplexer.
// Broadcast support is enabled with DMUX_N_BCAST_EN.
package dmux_n_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_e;

    // One bit of the load-enable vector: channel k loads on a transfer that
    // either targets it or is broadcast. Out-of-range selects match nothing.
    function automatic logic load_en(
        input int unsigned sel,
        input int unsigned k,
        input logic        xfer,
        input logic        bcast
    );
        return xfer & (bcast | (sel == k));
    endfunction

endpackage

// File: rtl/dmux_n_slot.sv
// Single-channel holding register with EMPTY/FULL state.
// Broadcast support (DMUX_N_BCAST_EN) needs nothing extra here.
module dmux_n_slot
    import dmux_n_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) data_d = load_data;
        unique case (state_q)
            CH_EMPTY: if (load) state_d = CH_FULL;
            // A load in the same cycle as a drain keeps the slot full.
            CH_FULL: if (!load && ready) state_d = CH_EMPTY;
            default: state_d = CH_EMPTY;
        endcase
    end

    assign valid = (state_q == CH_FULL);
    assign data  = data_q;

endmodule

// File: rtl/dmux_n.sv
// Registered N-way demultiplexer with valid/ready on every channel.
// Define DMUX_N_BCAST_EN to add the in_bcast broadcast port.
module dmux_n
    import dmux_n_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
`ifdef DMUX_N_BCAST_EN
    input  logic                      in_bcast,
`endif
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      err_oob
);

    logic [CHANNELS-1:0] slot_free;
    logic [CHANNELS-1:0] load;
    logic                sel_free;
    logic                oob;
    logic                bcast;
    logic                xfer;
    logic                err_d;

`ifdef DMUX_N_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign slot_free = ~out_valid | out_ready;
    assign oob       = 32'(in_sel) >= CHANNELS;

    always_comb begin
        sel_free = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (32'(in_sel) == k) sel_free = slot_free[k];
        end
    end

    // Out-of-range words are always accepted so they can be dropped.
    assign in_ready = bcast ? &slot_free : (oob | sel_free);
    assign xfer     = in_valid & in_ready;
    assign err_d    = xfer & oob & ~bcast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_oob <= 1'b0;
        else          err_oob <= err_d;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
        assign load[g] = load_en(32'(in_sel), 32'(g), xfer, bcast);

        dmux_n_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (load[g]),
            .load_data(in_data),
            .ready    (out_ready[g]),
            .valid    (out_valid[g]),
            .data     (out_data[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_dmux_n.sv
// Directed self-checking bench for dmux_n (4- and 5-channel instances).
module tb_dmux_n;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [15:0] d4_in_data;
    logic [1:0]  d4_in_sel;
    logic        d4_in_valid;
    logic        d4_in_ready;
    logic [63:0] d4_out_data;
    logic [3:0]  d4_out_valid;
    logic [3:0]  d4_out_ready;
    logic        d4_err;

    logic [15:0] d5_in_data;
    logic [2:0]  d5_in_sel;
    logic        d5_in_valid;
    logic        d5_in_ready;
    logic [79:0] d5_out_data;
    logic [4:0]  d5_out_valid;
    logic [4:0]  d5_out_ready;
    logic        d5_err;

`ifdef DMUX_N_BCAST_EN
    logic        d4_bcast;
    logic        d5_bcast;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmux_n #(.WIDTH(16), .CHANNELS(4)) u_d4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (d4_in_data),
        .in_sel   (d4_in_sel),
        .in_valid (d4_in_valid),
`ifdef DMUX_N_BCAST_EN
        .in_bcast (d4_bcast),
`endif
        .in_ready (d4_in_ready),
        .out_data (d4_out_data),
        .out_valid(d4_out_valid),
        .out_ready(d4_out_ready),
        .err_oob  (d4_err)
    );

    dmux_n #(.WIDTH(16), .CHANNELS(5)) u_d5 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (d5_in_data),
        .in_sel   (d5_in_sel),
        .in_valid (d5_in_valid),
`ifdef DMUX_N_BCAST_EN
        .in_bcast (d5_bcast),
`endif
        .in_ready (d5_in_ready),
        .out_data (d5_out_data),
        .out_valid(d5_out_valid),
        .out_ready(d5_out_ready),
        .err_oob  (d5_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        d4_in_data   = '0;
        d4_in_sel    = '0;
        d4_in_valid  = 1'b0;
        d4_out_ready = '0;
        d5_in_data   = '0;
        d5_in_sel    = '0;
        d5_in_valid  = 1'b0;
        d5_out_ready = '0;
`ifdef DMUX_N_BCAST_EN
        d4_bcast     = 1'b0;
        d5_bcast     = 1'b0;
`endif
        step();
        step();
        tests++;
        if (d4_out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL reset_valid got %b want 0000", d4_out_valid);
        end
        tests++;
        if (d4_out_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", d4_out_data);
        end
        tests++;
        if (d4_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err got %b want 0", d4_err);
        end
        tests++;
        if (d4_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", d4_in_ready);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_load_hold();
        d4_in_data  = 16'hA5A5;
        d4_in_sel   = 2'd2;
        d4_in_valid = 1'b1;
        #1;
        tests++;
        if (d4_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_ready got %b want 1", d4_in_ready);
        end
        step();
        tests++;
        if (d4_out_valid !== 4'b0100 || d4_out_data[47:32] !== 16'hA5A5) begin
            fails++;
            $display("FAIL load_out got v=%b d=%h want v=0100 d=a5a5",
                     d4_out_valid, d4_out_data[47:32]);
        end
        d4_in_data = 16'h5555;
        #1;
        tests++;
        if (d4_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_ready got %b want 0", d4_in_ready);
        end
        step();
        tests++;
        if (d4_out_valid !== 4'b0100 || d4_out_data[47:32] !== 16'hA5A5) begin
            fails++;
            $display("FAIL hold_out got v=%b d=%h want v=0100 d=a5a5",
                     d4_out_valid, d4_out_data[47:32]);
        end
        tests++;
        if (d4_err !== 1'b0) begin
            fails++;
            $display("FAIL hold_err got %b want 0", d4_err);
        end
    endtask

    task automatic test_replace();
        d4_out_ready = 4'b0100;
        d4_in_data   = 16'h1234;
        d4_in_sel    = 2'd2;
        d4_in_valid  = 1'b1;
        #1;
        tests++;
        if (d4_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL replace_ready got %b want 1", d4_in_ready);
        end
        step();
        d4_in_valid = 1'b0;
        tests++;
        if (d4_out_valid !== 4'b0100 || d4_out_data[47:32] !== 16'h1234) begin
            fails++;
            $display("FAIL replace_out got v=%b d=%h want v=0100 d=1234",
                     d4_out_valid, d4_out_data[47:32]);
        end
        step();
        tests++;
        if (d4_out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL drain_valid got %b want 0000", d4_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_v;
        logic [15:0] exp_d;
        d4_out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            d4_in_data  = 16'(i + 1);
            d4_in_sel   = 2'(i);
            d4_in_valid = 1'b1;
            #1;
            tests++;
            if (d4_in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, d4_in_ready);
            end
            step();
            exp_v = 4'b0001 << i;
            exp_d = 16'(i + 1);
            tests++;
            if (d4_out_valid !== exp_v || d4_out_data[i*16 +: 16] !== exp_d) begin
                fails++;
                $display("FAIL b2b_out[%0d] got v=%b d=%h want v=%b d=%h",
                         i, d4_out_valid, d4_out_data[i*16 +: 16], exp_v, exp_d);
            end
        end
        d4_in_valid = 1'b0;
        step();
        tests++;
        if (d4_out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL b2b_drain got %b want 0000", d4_out_valid);
        end
        d4_out_ready = 4'b0000;
    endtask

    task automatic test_oob();
        d5_in_data  = 16'h0042;
        d5_in_sel   = 3'd1;
        d5_in_valid = 1'b1;
        step();
        d5_in_data = 16'hDEAD;
        d5_in_sel  = 3'd7;
        #1;
        tests++;
        if (d5_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL oob_ready got %b want 1", d5_in_ready);
        end
        step();
        d5_in_valid = 1'b0;
        tests++;
        if (d5_err !== 1'b1 || d5_out_valid !== 5'b00010) begin
            fails++;
            $display("FAIL oob_pulse got err=%b v=%b want err=1 v=00010",
                     d5_err, d5_out_valid);
        end
        tests++;
        if (d5_out_data[31:16] !== 16'h0042) begin
            fails++;
            $display("FAIL oob_keep got %h want 0042", d5_out_data[31:16]);
        end
        step();
        tests++;
        if (d5_err !== 1'b0 || d5_out_valid !== 5'b00010) begin
            fails++;
            $display("FAIL oob_end got err=%b v=%b want err=0 v=00010",
                     d5_err, d5_out_valid);
        end
    endtask

    task automatic test_async_reset();
        d4_in_valid = 1'b1;
        d4_in_data  = 16'h0C0C;
        d4_in_sel   = 2'd0;
        step();
        d4_in_data  = 16'h3C3C;
        d4_in_sel   = 2'd3;
        step();
        d4_in_valid = 1'b0;
        tests++;
        if (d4_out_valid !== 4'b1001) begin
            fails++;
            $display("FAIL pre_reset_valid got %b want 1001", d4_out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (d4_out_valid !== 4'b0000 || d4_out_data !== 64'h0) begin
            fails++;
            $display("FAIL async_reset got v=%b d=%h want v=0000 d=0",
                     d4_out_valid, d4_out_data);
        end
        tests++;
        if (d5_out_valid !== 5'b00000) begin
            fails++;
            $display("FAIL async_reset5 got %b want 00000", d5_out_valid);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

`ifdef DMUX_N_BCAST_EN
    task automatic test_bcast();
        d4_bcast    = 1'b1;
        d4_in_data  = 16'hBEEF;
        d4_in_sel   = 2'd1;
        d4_in_valid = 1'b1;
        #1;
        tests++;
        if (d4_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bcast_ready got %b want 1", d4_in_ready);
        end
        step();
        d4_in_valid = 1'b0;
        d4_bcast    = 1'b0;
        tests++;
        if (d4_out_valid !== 4'b1111 || d4_out_data !== {4{16'hBEEF}}) begin
            fails++;
            $display("FAIL bcast_out got v=%b d=%h want v=1111 d=beef x4",
                     d4_out_valid, d4_out_data);
        end
        tests++;
        if (d4_err !== 1'b0) begin
            fails++;
            $display("FAIL bcast_err got %b want 0", d4_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_hold();
        test_replace();
        test_back_to_back();
        test_oob();
        test_async_reset();
`ifdef DMUX_N_BCAST_EN
        test_bcast();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
